// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage.
// Issues requests to instruction memory and tolerates wait states. Fetched
// words go into a registered output slot (instr/pc_plus4/instr_valid). A
// one-entry pending slot holds a word that returns while the output is stalled.
// Taken branches and jumps redirect the PC and flush both slots. A response
// that is still outstanding at redirect time is drained in S_DROP and discarded.
// Optional feature macro: IF_FETCH_PERF_EN adds fetch_count / stall_count.

module if_fetch_unit (
  input  logic        clk,
  input  logic        res,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_plus4,
  output logic        instr_valid
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PEND,
    S_DROP
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        req_n;
  logic [31:0] addr_n;
  logic [31:0] instr_n, pc4_n;
  logic        valid_n;
  logic [31:0] pend_instr, pend_instr_n;
  logic [31:0] pend_pc4, pend_pc4_n;
  logic        load_out;

  logic        consume;
  logic        out_free;
  logic        redirect;
  logic        resp;
  logic [31:0] jump_target;
  logic [31:0] redirect_target;

  // The decode stage takes the current word this cycle.
  assign consume  = instr_valid & ~stall;
  // The output slot can take new data at the next edge.
  assign out_free = ~instr_valid | ~stall;
  // A jump only matters when the instruction carrying it is valid.
  assign redirect = branch_taken | (jump & instr_valid);
  assign resp     = imem_req & imem_ack;

  assign jump_target     = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign redirect_target = branch_taken ? branch_target : jump_target;

  assign opcode = instr[31:26];

  // Next-state and next-output logic for the fetch FSM and its datapath.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_n      = state;
    pc_n         = pc;
    req_n        = imem_req;
    addr_n       = imem_addr;
    instr_n      = instr;
    pc4_n        = pc_plus4;
    valid_n      = instr_valid;
    pend_instr_n = pend_instr;
    pend_pc4_n   = pend_pc4;
    load_out     = 1'b0;

    unique case (state)
      S_IDLE: begin
        state_n = S_FETCH;
        req_n   = 1'b1;
        pc_n    = redirect ? redirect_target : pc;
        addr_n  = redirect ? redirect_target : pc;
        valid_n = 1'b0;
      end

      S_FETCH, S_WAIT: begin
        if (redirect) begin
          valid_n = 1'b0;
          pc_n    = redirect_target;
          if (imem_req && !imem_ack) begin
            // The memory still owes us a response. Keep the request stable and drain it.
            state_n = S_DROP;
          end else begin
            // Drop any same-cycle response and restart at the target.
            state_n = S_FETCH;
            req_n   = 1'b1;
            addr_n  = redirect_target;
          end
        end else if (resp) begin
          pc_n = pc + 32'd4;
          if (out_free) begin
            instr_n  = imem_rdata;
            pc4_n    = imem_addr + 32'd4;
            valid_n  = 1'b1;
            load_out = 1'b1;
            state_n  = S_FETCH;
            req_n    = 1'b1;
            addr_n   = pc + 32'd4;
          end else begin
            // The output is held by a stall, so park the word and stop fetching.
            pend_instr_n = imem_rdata;
            pend_pc4_n   = imem_addr + 32'd4;
            state_n      = S_PEND;
            req_n        = 1'b0;
          end
        end else if (imem_req) begin
          state_n = S_WAIT;
          if (consume) valid_n = 1'b0;
        end else begin
          if (out_free) begin
            req_n  = 1'b1;
            addr_n = pc;
          end
          if (consume) valid_n = 1'b0;
        end
      end

      S_PEND: begin
        if (redirect) begin
          valid_n = 1'b0;
          pc_n    = redirect_target;
          state_n = S_FETCH;
          req_n   = 1'b1;
          addr_n  = redirect_target;
        end else if (consume) begin
          instr_n  = pend_instr;
          pc4_n    = pend_pc4;
          valid_n  = 1'b1;
          load_out = 1'b1;
          state_n  = S_FETCH;
          req_n    = 1'b1;
          addr_n   = pc;
        end
      end

      S_DROP: begin
        valid_n = 1'b0;
        if (redirect) pc_n = redirect_target;
        if (imem_ack) begin
          state_n = S_FETCH;
          req_n   = 1'b1;
          addr_n  = redirect ? redirect_target : pc;
        end
      end

      default: begin
        state_n = S_IDLE;
        req_n   = 1'b0;
        valid_n = 1'b0;
      end
    endcase
  end

  // State, PC, request and output registers; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (res) begin
      state       <= S_IDLE;
      pc          <= 32'd0;
      imem_req    <= 1'b0;
      imem_addr   <= 32'd0;
      instr       <= 32'd0;
      pc_plus4    <= 32'd0;
      instr_valid <= 1'b0;
      pend_instr  <= 32'd0;
      pend_pc4    <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state       <= state_n;
      pc          <= pc_n;
      imem_req    <= req_n;
      imem_addr   <= addr_n;
      instr       <= instr_n;
      pc_plus4    <= pc4_n;
      instr_valid <= valid_n;
      pend_instr  <= pend_instr_n;
      pend_pc4    <= pend_pc4_n;
    end
  end

`ifdef IF_FETCH_PERF_EN
  // Performance counters: words loaded into the output, and cycles spent stalled with valid output.
  always_ff @(posedge clk) begin
    if (res) begin
      fetch_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (load_out)             fetch_count <= fetch_count + 32'd1;
      if (instr_valid && stall) stall_count <= stall_count + 32'd1;
    end
  end
`else
  // load_out only feeds the performance counters.
  logic unused_load_out;
  assign unused_load_out = load_out;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed bench for if_fetch_unit.
// The stimulus pushes expected deliveries into a queue. A monitor pops one
// entry whenever the DUT hands over an instruction (instr_valid & ~stall).
// A behavioural memory answers requests after a programmable delay.

module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        res;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc_plus4;
  logic        instr_valid;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ack_delay = 0;
  int   wait_cnt = 0;
  logic force_ack = 1'b0;

  if_fetch_unit dut (
    .clk           (clk),
    .res           (res),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .instr         (instr),
    .opcode        (opcode),
    .pc_plus4      (pc_plus4),
    .instr_valid   (instr_valid)
`ifdef IF_FETCH_PERF_EN
    ,
    .fetch_count   (fetch_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0014) return 32'hDEAD_BEEF;
    if (a == 32'h1000_0004) return 32'h0800_0010;
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.instr = mem_word(a);
    e.pc4   = a + 32'd4;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural instruction memory: acks after ack_delay wait cycles.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      if (force_ack) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
      end else if (imem_req === 1'b1) begin
        if (wait_cnt >= ack_delay) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wait_cnt   = 0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 32'd0;
          wait_cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: compare each delivered instruction against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (instr_valid === 1'b1 && stall === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got instr %h pc_plus4 %h, nothing expected (t=%0t)",
                   instr, pc_plus4, $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_instr", instr, e.instr);
          check("sb_pc_plus4", pc_plus4, e.pc4);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  // Directed stimulus.
  initial begin
    res = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h500; jump = 1'b1;
    repeat (3) tick();
    res = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0; jump = 1'b0;

    // Reset state; the reset cycles also carried a branch and a stall.
    @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc_plus4", pc_plus4, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_opcode", {26'd0, opcode}, 32'd0);

    push(32'h0); push(32'h4); push(32'h8);
    push(32'h100); push(32'h104); push(32'h108);

    // Zero-wait streaming from address 0.
    tick(); @(negedge clk);
    check("s1_req", {31'd0, imem_req}, 32'd1);
    check("s1_addr", imem_addr, 32'h0);
    check("s1_valid", {31'd0, instr_valid}, 32'd0);
    tick(); @(negedge clk);
    check("s2_addr", imem_addr, 32'h4);
    check("s2_valid", {31'd0, instr_valid}, 32'd1);
    tick(); @(negedge clk);
    check("s3_addr", imem_addr, 32'h8);

    // Branch and jump in the same cycle: the branch wins.
    tick(); branch_taken = 1'b1; branch_target = 32'h100; jump = 1'b1;
    @(negedge clk);
    check("s4_addr", imem_addr, 32'hC);
    tick(); branch_taken = 1'b0; jump = 1'b0;
    @(negedge clk);
    check("br_addr", imem_addr, 32'h100);
    check("br_valid", {31'd0, instr_valid}, 32'd0);

    // Two stall cycles with valid output: the next word goes to the pending slot.
    tick(); stall = 1'b1;
    @(negedge clk);
    check("st0_pc_plus4", pc_plus4, 32'h104);
    tick(); @(negedge clk);
    check("st1_req", {31'd0, imem_req}, 32'd0);
    check("st1_valid", {31'd0, instr_valid}, 32'd1);
    check("st1_instr", instr, mem_word(32'h100));
    tick(); stall = 1'b0;
    @(negedge clk);
    check("pend_req", {31'd0, imem_req}, 32'd0);
    tick(); @(negedge clk);
    check("rel_req", {31'd0, imem_req}, 32'd1);
    check("rel_addr", imem_addr, 32'h108);
    check("rel_pc_plus4", pc_plus4, 32'h108);

    // Redirect to 0x10, then three wait states on that request.
    tick(); branch_taken = 1'b1; branch_target = 32'h10;
    @(negedge clk);
    tick(); branch_taken = 1'b0; ack_delay = 3; push(32'h10);
    @(negedge clk);
    check("w0_addr", imem_addr, 32'h10);
    check("w0_valid", {31'd0, instr_valid}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick(); @(negedge clk);
      check("w_req", {31'd0, imem_req}, 32'd1);
      check("w_addr", imem_addr, 32'h10);
      check("w_valid", {31'd0, instr_valid}, 32'd0);
    end
    tick(); @(negedge clk);
    check("w_done_valid", {31'd0, instr_valid}, 32'd1);
    check("w_done_pc_plus4", pc_plus4, 32'h14);

    // Redirect to 0x40 while waiting; the late 0xDEADBEEF response must be dropped.
    tick(); branch_taken = 1'b1; branch_target = 32'h40;
    @(negedge clk);
    check("cons_clears_valid", {31'd0, instr_valid}, 32'd0);
    check("drop0_addr", imem_addr, 32'h14);
    tick(); branch_taken = 1'b0;
    @(negedge clk);
    check("drop1_addr", imem_addr, 32'h14);
    tick(); @(negedge clk);
    check("drop2_req", {31'd0, imem_req}, 32'd1);
    check("drop2_addr", imem_addr, 32'h14);

    // After the drain, fetch resumes at 0x40. Then branch to the jump instruction.
    tick(); ack_delay = 0; branch_taken = 1'b1; branch_target = 32'h1000_0004;
    push(32'h1000_0004); push(32'h1000_0040);
    @(negedge clk);
    check("drop_done_addr", imem_addr, 32'h40);
    check("drop_done_valid", {31'd0, instr_valid}, 32'd0);
    tick(); branch_taken = 1'b0;
    @(negedge clk);
    check("j_fetch_addr", imem_addr, 32'h1000_0004);

    // Jump with instr=0x08000010 and pc_plus4=0x10000008 targets 0x10000040.
    tick(); jump = 1'b1;
    @(negedge clk);
    check("j_opcode", {26'd0, opcode}, 32'h2);
    check("j_pc_plus4", pc_plus4, 32'h1000_0008);
    tick(); @(negedge clk);
    check("j_target_addr", imem_addr, 32'h1000_0040);
    check("j_valid", {31'd0, instr_valid}, 32'd0);
    // Jump held high while instr_valid=0 must be ignored.
    tick(); jump = 1'b0; ack_delay = 10;
    @(negedge clk);
    check("j_ignored_addr", imem_addr, 32'h1000_0044);
    check("j_ignored_valid", {31'd0, instr_valid}, 32'd1);

    // Reset during an outstanding request, with a stray ack right after reset.
    tick(); res = 1'b1;
    @(negedge clk);
    check("pre_rst_valid", {31'd0, instr_valid}, 32'd0);
    tick(); res = 1'b0; force_ack = 1'b1; ack_delay = 0; push(32'h0);
    @(negedge clk);
    check("mid_rst_req", {31'd0, imem_req}, 32'd0);
    check("mid_rst_addr", imem_addr, 32'd0);
    check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    tick(); force_ack = 1'b0;
    @(negedge clk);
    check("post_rst_req", {31'd0, imem_req}, 32'd1);
    check("post_rst_addr", imem_addr, 32'd0);
    check("post_rst_valid", {31'd0, instr_valid}, 32'd0);
    tick(); @(negedge clk);
    check("post_rst_instr", instr, mem_word(32'h0));
    tick(); stall = 1'b1;
    @(negedge clk);
    repeat (2) begin
      tick(); @(negedge clk);
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
